// File: rtl/pc_seq.sv
// Program-flow sequencer: drives PC increment/branch controls, with a call/return stack, WAIT stall and HALT.
// PC controls are combinational from state and cmd; state, sp, waiting, halted and stack_err update on the same edge as the PC.
module pc_seq #(
  parameter int Psize = 6,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       cmd,
  input  logic [Psize-1:0] target,
  input  logic             zflag,
  input  logic             go,
  input  logic [Psize-1:0] PCout,
  output logic             PCincr,
  output logic             PCabsbranch,
  output logic             PCrelbranch,
  output logic [Psize-1:0] Branchaddr,
  output logic             waiting,
  output logic             halted,
  output logic             stack_err
);

  localparam int SpW  = $clog2(Depth + 1);
  localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [2:0] CMD_NEXT = 3'd0;
  localparam logic [2:0] CMD_JMP  = 3'd1;
  localparam logic [2:0] CMD_BR   = 3'd2;
  localparam logic [2:0] CMD_BEQ  = 3'd3;
  localparam logic [2:0] CMD_CALL = 3'd4;
  localparam logic [2:0] CMD_RET  = 3'd5;
  localparam logic [2:0] CMD_WAIT = 3'd6;

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_HALT} state_t;

  state_t           state_q, state_d;
  logic [SpW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic             waiting_q, waiting_d;
  logic             halted_q, halted_d;
  logic [Psize-1:0] stack_q [Depth];

  logic             push;
  logic [Psize-1:0] push_dat;
  logic [IdxW-1:0]  push_idx;
  logic [IdxW-1:0]  top_idx;
  logic             full;
  logic             empty;

  assign full     = (sp_q == SpW'(Depth));
  assign empty    = (sp_q == '0);
  assign push_idx = IdxW'(sp_q);
  assign top_idx  = IdxW'(sp_q - SpW'(1));
  assign push_dat = PCout + Psize'(1);

  always_comb begin
    PCincr      = 1'b0;
    PCabsbranch = 1'b0;
    PCrelbranch = 1'b0;
    Branchaddr  = '0;
    state_d     = state_q;
    sp_d        = sp_q;
    err_d       = err_q;
    push        = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_RUN: begin
          unique case (cmd)
            CMD_NEXT: PCincr = 1'b1;
            CMD_JMP: begin
              PCabsbranch = 1'b1;
              Branchaddr  = target;
            end
            CMD_BR: begin
              PCrelbranch = 1'b1;
              Branchaddr  = target;
            end
            CMD_BEQ: begin
              if (zflag) begin
                PCrelbranch = 1'b1;
                Branchaddr  = target;
              end else begin
                PCincr = 1'b1;
              end
            end
            CMD_CALL: begin
              if (!full) begin
                push        = 1'b1;
                sp_d        = sp_q + SpW'(1);
                PCabsbranch = 1'b1;
                Branchaddr  = target;
              end else begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end
            end
            CMD_RET: begin
              if (!empty) begin
                sp_d        = sp_q - SpW'(1);
                PCabsbranch = 1'b1;
                Branchaddr  = stack_q[top_idx];
              end else begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end
            end
            CMD_WAIT: state_d = ST_WAIT;
            default:  state_d = ST_HALT;
          endcase
        end
        ST_WAIT: begin
          // cmd is ignored here: the PC is parked on the WAIT instruction
          if (go) begin
            PCincr  = 1'b1;
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign waiting_d = (state_d == ST_WAIT);
  assign halted_d  = (state_d == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      sp_q      <= '0;
      err_q     <= 1'b0;
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      err_q     <= err_d;
      waiting_q <= waiting_d;
      halted_q  <= halted_d;
    end
    // Stack contents survive reset; only the pointer is cleared.
    if (push) stack_q[push_idx] <= push_dat;
  end

  assign waiting   = waiting_q;
  assign halted    = halted_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Scoreboard bench for pc_seq: each driven cycle queues its expected PC controls and status flags.
module tb_pc_seq;

  localparam logic [2:0] NXT = 3'd0, JMP = 3'd1, BR = 3'd2, BEQ = 3'd3;
  localparam logic [2:0] CAL = 3'd4, RET = 3'd5, WAT = 3'd6, HLT = 3'd7;
  localparam logic [8:0] C_NONE = 9'd0;
  localparam logic [8:0] C_INC  = 9'b100_000000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cmd = 3'd0;
  logic [5:0] target = 6'd0;
  logic       zflag = 1'b0;
  logic       go = 1'b0;
  logic [5:0] PCout = 6'd0;
  logic       PCincr, PCabsbranch, PCrelbranch;
  logic [5:0] Branchaddr;
  logic       waiting, halted, stack_err;

  typedef struct {
    int         idx;
    logic [8:0] ctrl;
    logic [2:0] flags;
  } exp_t;

  exp_t exp_q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc_idx  = 0;

  pc_seq #(.Psize(6), .Depth(4)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .target(target), .zflag(zflag),
    .go(go), .PCout(PCout), .PCincr(PCincr), .PCabsbranch(PCabsbranch),
    .PCrelbranch(PCrelbranch), .Branchaddr(Branchaddr), .waiting(waiting),
    .halted(halted), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [8:0] c_abs(input logic [5:0] a);
    return {3'b010, a};
  endfunction

  function automatic logic [8:0] c_rel(input logic [5:0] a);
    return {3'b001, a};
  endfunction

  // One cycle: inputs applied after the edge; ctrl = {incr,abs,rel,addr}, fl = {waiting,halted,stack_err}.
  task automatic drive(input logic r, input logic [2:0] c, input logic [5:0] t,
                       input logic z, input logic g, input logic [5:0] pc,
                       input logic [8:0] ctrl, input logic [2:0] fl);
    exp_t e;
    @(posedge clk);
    #1;
    reset  = r;
    cmd    = c;
    target = t;
    zflag  = z;
    go     = g;
    PCout  = pc;
    e.idx   = cyc_idx;
    e.ctrl  = ctrl;
    e.flags = fl;
    exp_q.push_back(e);
    cyc_idx++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("ctrl#%0d", e.idx), {23'd0, PCincr, PCabsbranch, PCrelbranch, Branchaddr}, {23'd0, e.ctrl});
      chk($sformatf("flags#%0d", e.idx), {29'd0, waiting, halted, stack_err}, {29'd0, e.flags});
    end
  end

  initial begin
    // First reset edge establishes known flop state; nothing is checked before it.
    @(posedge clk);
    #1;
    // Reset dominates a held JMP.
    drive(1, JMP, 6'd5, 0, 0, 6'd0, C_NONE, 3'b000);
    drive(0, NXT, 6'd0, 0, 0, 6'd0, C_INC, 3'b000);
    chk("sp_after_reset", {29'd0, dut.sp_q}, 32'd0);

    // CALL then RET.
    drive(0, CAL, 6'd40, 0, 0, 6'd10, c_abs(6'd40), 3'b000);
    drive(0, RET, 6'd0,  0, 0, 6'd40, c_abs(6'd11), 3'b000);
    drive(0, NXT, 6'd0,  0, 0, 6'd11, C_INC, 3'b000);
    chk("sp_after_ret", {29'd0, dut.sp_q}, 32'd0);

    // Return address wraps modulo 2^6.
    drive(0, CAL, 6'd2, 0, 0, 6'd63, c_abs(6'd2), 3'b000);
    drive(0, RET, 6'd0, 0, 0, 6'd2,  c_abs(6'd0), 3'b000);

    // Fill the stack, then overflow.
    for (int i = 1; i <= 4; i++)
      drive(0, CAL, 6'(20 + i), 0, 0, 6'(i), c_abs(6'(20 + i)), 3'b000);
    chk("sp_full", {29'd0, dut.sp_q}, 32'd3);
    drive(0, CAL, 6'd30, 0, 0, 6'd5, C_NONE, 3'b000);
    drive(0, NXT, 6'd0,  0, 0, 6'd5, C_NONE, 3'b011);
    drive(1, NXT, 6'd0,  0, 0, 6'd5, C_NONE, 3'b011);
    drive(0, NXT, 6'd0,  0, 0, 6'd0, C_INC, 3'b000);

    // Underflow from an empty stack.
    drive(0, RET, 6'd0, 0, 0, 6'd1, C_NONE, 3'b000);
    drive(0, NXT, 6'd0, 0, 0, 6'd1, C_NONE, 3'b011);
    drive(1, NXT, 6'd0, 0, 0, 6'd1, C_NONE, 3'b011);
    drive(0, NXT, 6'd0, 0, 0, 6'd0, C_INC, 3'b000);

    // Branches.
    drive(0, BEQ, 6'b111110, 1, 0, 6'd8, c_rel(6'd62), 3'b000);
    drive(0, BEQ, 6'b111110, 0, 0, 6'd6, C_INC, 3'b000);
    drive(0, BR,  6'd3,      0, 0, 6'd7, c_rel(6'd3), 3'b000);
    drive(0, JMP, 6'd17,     0, 0, 6'd10, c_abs(6'd17), 3'b000);

    // WAIT with go low, cmd ignored while stalled.
    drive(0, WAT, 6'd0, 0, 0, 6'd17, C_NONE, 3'b000);
    for (int i = 0; i < 3; i++)
      drive(0, JMP, 6'd9, 0, 0, 6'd17, C_NONE, 3'b100);
    drive(0, JMP, 6'd9, 0, 1, 6'd17, C_INC, 3'b100);
    drive(0, NXT, 6'd0, 0, 0, 6'd18, C_INC, 3'b000);

    // go already high when WAIT is decoded: one stall cycle.
    drive(0, WAT, 6'd0, 0, 1, 6'd19, C_NONE, 3'b000);
    drive(0, NXT, 6'd0, 0, 1, 6'd19, C_INC, 3'b100);
    drive(0, NXT, 6'd0, 0, 0, 6'd20, C_INC, 3'b000);

    // Reset out of WAIT.
    drive(0, WAT, 6'd0, 0, 0, 6'd21, C_NONE, 3'b000);
    drive(1, NXT, 6'd0, 0, 1, 6'd21, C_NONE, 3'b100);
    drive(0, NXT, 6'd0, 0, 0, 6'd0,  C_INC, 3'b000);

    // HALT holds until reset.
    drive(0, HLT, 6'd0, 0, 0, 6'd1, C_NONE, 3'b000);
    for (int i = 0; i < 5; i++)
      drive(0, NXT, 6'd0, 0, 1, 6'd1, C_NONE, 3'b010);
    drive(1, NXT, 6'd0, 0, 0, 6'd1, C_NONE, 3'b010);
    drive(0, NXT, 6'd0, 0, 0, 6'd0, C_INC, 3'b000);

    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
